// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: divides Clk_In by a loadable period with a loadable high time,
// emits a per-period Tick, and reloads configuration only at period boundaries or while idle.
module clk_div_prog #(
    parameter int unsigned DIV_WIDTH    = 24,
    parameter int unsigned DEFAULT_DIV  = 25000,
    parameter int unsigned DEFAULT_HIGH = 12500
) (
    input  logic                 Clk_In,
    input  logic                 RST,
    input  logic                 En,
    input  logic                 Load,
    input  logic [DIV_WIDTH-1:0] Div_In,
    input  logic [DIV_WIDTH-1:0] High_In,
    output logic                 Clk_Out,
    output logic                 Tick,
    output logic                 Pend,
    output logic                 Cfg_Err
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DEF_HIGH = DIV_WIDTH'(DEFAULT_HIGH);
    localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO      = DIV_WIDTH'(2);

    logic [DIV_WIDTH-1:0] cnt_q,   cnt_d;
    logic [DIV_WIDTH-1:0] div_q,   div_d;
    logic [DIV_WIDTH-1:0] high_q,  high_d;
    logic [DIV_WIDTH-1:0] pdiv_q,  pdiv_d;
    logic [DIV_WIDTH-1:0] phigh_q, phigh_d;
    logic                 pend_q,  pend_d;
    logic                 clk_q,   clk_d;
    logic                 tick_q,  tick_d;
    logic                 err_q,   err_d;

    logic                 load_ok_c;
    logic                 boundary_c;
    logic [DIV_WIDTH-1:0] apply_div_c;
    logic [DIV_WIDTH-1:0] apply_high_c;

    // Config candidate for this edge: same-cycle valid Load beats pending, pending beats current.
    always_comb begin
        load_ok_c    = Load && (Div_In >= TWO) && (High_In != '0) && (High_In < Div_In);
        boundary_c   = (cnt_q == (div_q - ONE));
        apply_div_c  = div_q;
        apply_high_c = high_q;
        if (load_ok_c) begin
            apply_div_c  = Div_In;
            apply_high_c = High_In;
        end else if (pend_q) begin
            apply_div_c  = pdiv_q;
            apply_high_c = phigh_q;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        high_d  = high_q;
        pdiv_d  = pdiv_q;
        phigh_d = phigh_q;
        pend_d  = pend_q;
        clk_d   = 1'b0;
        tick_d  = 1'b0;
        err_d   = Load && !load_ok_c;

        if (En) begin
            if (boundary_c) begin
                cnt_d  = '0;
                div_d  = apply_div_c;
                high_d = apply_high_c;
                pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q + ONE;
                if (load_ok_c) begin
                    pdiv_d  = Div_In;
                    phigh_d = High_In;
                    pend_d  = 1'b1;
                end
            end
            clk_d  = (cnt_d < high_d);
            tick_d = (cnt_d == '0);
        end else begin
            // Idle: apply immediately and arm the counter so the first enabled edge wraps to 0.
            div_d  = apply_div_c;
            high_d = apply_high_c;
            pend_d = 1'b0;
            cnt_d  = apply_div_c - ONE;
        end
    end

    always_ff @(posedge Clk_In) begin
        if (RST) begin
            cnt_q   <= DEF_DIV - ONE;
            div_q   <= DEF_DIV;
            high_q  <= DEF_HIGH;
            pdiv_q  <= DEF_DIV;
            phigh_q <= DEF_HIGH;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            pdiv_q  <= pdiv_d;
            phigh_q <= phigh_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    assign Clk_Out = clk_q;
    assign Tick    = tick_q;
    assign Pend    = pend_q;
    assign Cfg_Err = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios plus randomized traffic against a cycle-level model.
module tb_clk_div_prog;

    localparam int unsigned W    = 8;
    localparam int unsigned DDIV = 4;
    localparam int unsigned DHI  = 2;

    logic         clk = 1'b0;
    logic         rst, en, ld;
    logic [W-1:0] div_in, high_in;
    logic         clk_out, tick, pend, cfg_err;

    int checks   = 0;
    int failures = 0;

    // Model: position within the current period plus active/pending configuration.
    int  m_pos, m_div, m_high, m_pdiv, m_phigh;
    bit  m_pend;
    logic e_clk, e_tick, e_pend, e_err;

    clk_div_prog #(.DIV_WIDTH(W), .DEFAULT_DIV(DDIV), .DEFAULT_HIGH(DHI)) dut (
        .Clk_In(clk), .RST(rst), .En(en), .Load(ld),
        .Div_In(div_in), .High_In(high_in),
        .Clk_Out(clk_out), .Tick(tick), .Pend(pend), .Cfg_Err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit l, input int d, input int h);
        bit ok;
        if (r) begin
            m_div = DDIV; m_high = DHI; m_pos = DDIV - 1; m_pend = 0;
            e_clk = 0; e_tick = 0; e_err = 0;
        end else begin
            ok    = l && d >= 2 && h >= 1 && h < d;
            e_err = l && !ok;
            if (e && m_pos == m_div - 1) begin
                if (ok) begin m_div = d; m_high = h; end
                else if (m_pend) begin m_div = m_pdiv; m_high = m_phigh; end
                m_pend = 0;
                m_pos  = 0;
            end else if (e) begin
                m_pos++;
                if (ok) begin m_pdiv = d; m_phigh = h; m_pend = 1; end
            end else begin
                if (ok) begin m_div = d; m_high = h; end
                else if (m_pend) begin m_div = m_pdiv; m_high = m_phigh; end
                m_pend = 0;
                m_pos  = m_div - 1;
            end
            e_clk  = e && (m_pos < m_high);
            e_tick = e && (m_pos == 0);
        end
        e_pend = m_pend;
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic step(input bit r, input bit e, input bit l, input int d, input int h);
        rst = r; en = e; ld = l;
        div_in = W'(d); high_in = W'(h);
        @(posedge clk);
        model(r, e, l, d, h);
        #1;
        chk("clk_out", clk_out, e_clk);
        chk("tick",    tick,    e_tick);
        chk("pend",    pend,    e_pend);
        chk("cfg_err", cfg_err, e_err);
    endtask

    initial begin
        logic [0:7] pat_clk;
        logic [0:7] pat_tick;
        pat_clk  = 8'b1100_1100;
        pat_tick = 8'b1000_1000;
        rst = 1'b1; en = 1'b0; ld = 1'b0; div_in = '0; high_in = '0;

        // Reset state
        step(1, 0, 0, 0, 0);
        chk("rst_clk", clk_out, 1'b0);
        chk("rst_pend", pend, 1'b0);

        // Default 4/2 waveform
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 0);
            chk("def_clk", clk_out, pat_clk[i]);
            chk("def_tick", tick, pat_tick[i]);
        end

        // Mid-period load 5/2: current period finishes as 4, then 11000
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 5, 2);
        chk("load_pend", pend, 1'b1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("old_period_pend", pend, 1'b1);
        step(0, 1, 0, 0, 0);
        chk("new_tick", tick, 1'b1);
        chk("new_pend", pend, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        chk("p5_last_low", clk_out, 1'b0);
        step(0, 1, 0, 0, 0);
        chk("p5_wrap_tick", tick, 1'b1);

        // Invalid loads
        step(0, 1, 1, 5, 5);
        chk("err_high_eq_div", cfg_err, 1'b1);
        step(0, 1, 0, 0, 0);
        chk("err_clear", cfg_err, 1'b0);
        step(0, 1, 1, 1, 0);
        chk("err_div1", cfg_err, 1'b1);

        // Boundary-cycle load while pending wins over the pending config
        step(0, 1, 1, 6, 3);
        chk("pend_before_bnd", pend, 1'b1);
        step(0, 1, 1, 3, 1);
        chk("bnd_tick", tick, 1'b1);
        chk("bnd_pend", pend, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

        // En drop mid-high, then restart
        step(0, 0, 1, 6, 4);
        step(0, 1, 0, 0, 0);
        chk("restart_tick", tick, 1'b1);
        chk("restart_clk", clk_out, 1'b1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("en_drop_clk", clk_out, 1'b0);
        step(0, 1, 0, 0, 0);
        chk("reen_tick", tick, 1'b1);
        chk("reen_clk", clk_out, 1'b1);

        // Reset while pending
        step(0, 1, 1, 7, 3);
        chk("pre_rst_pend", pend, 1'b1);
        step(1, 1, 0, 0, 0);
        chk("rst_pend_clear", pend, 1'b0);
        chk("rst_clk_low", clk_out, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 0);
            chk("post_rst_clk", clk_out, pat_clk[i]);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 12)),
                 int'($urandom_range(0, 12)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
